// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end for a single shared sequential
// 16x8 shift-add multiplier. Requesters present operand pairs as levels;
// one job at a time is issued with a start/busy handshake and the 24-bit
// product is returned tagged with the owning requester index.
module mult_arbiter #(
  parameter int N = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N-1:0]            req_i,
  input  logic [16*N-1:0]         a_i,
  input  logic [8*N-1:0]          b_i,
  output logic [N-1:0]            gnt_o,
  output logic                    done_o,
  output logic [$clog2(N)-1:0]    done_id_o,
  output logic [23:0]             y_o,
  output logic                    busy_o,
  output logic                    mult_start_o,
  output logic [15:0]             mult_a_o,
  output logic [7:0]              mult_b_o,
  input  logic                    mult_busy_i,
  input  logic [23:0]             mult_y_i
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  logic [1:0]    state_r;
  logic [IW-1:0] rr_r;
  logic [IW-1:0] idx_r;
  logic [N-1:0]  gnt_r;
  logic          done_r;
  logic [IW-1:0] done_id_r;
  logic [23:0]   y_r;
  logic          busy_r;
  logic          start_r;
  logic [15:0]   a_r;
  logic [7:0]    b_r;

  logic          sel_found_s;
  logic [IW-1:0] sel_idx_s;
  logic [IW-1:0] cand_s;
  logic [N-1:0]  sel_oh_s;
  logic [15:0]   sel_a_s;
  logic [7:0]    sel_b_s;
  logic [IW-1:0] rr_next_s;

  // Round-robin pick: walk offsets from the highest down so the lowest
  // offset from the pointer (highest priority) is the one that sticks.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand_s      = IW'((int'(rr_r) + i) % N);
      sel_found_s = sel_found_s | req_i[cand_s];
      sel_idx_s   = req_i[cand_s] ? cand_s : sel_idx_s;
    end
  end

  // Operand mux, one-hot grant vector and pointer advance for the winner.
  always_comb begin
    sel_oh_s = '0;
    sel_a_s  = 16'h0000;
    sel_b_s  = 8'h00;
    for (int k = 0; k < N; k++) begin
      sel_oh_s[k] = (sel_idx_s == IW'(k));
      sel_a_s     = sel_oh_s[k] ? a_i[16*k +: 16] : sel_a_s;
      sel_b_s     = sel_oh_s[k] ? b_i[8*k +: 8]   : sel_b_s;
    end
    rr_next_s = (sel_idx_s == IW'(N - 1)) ? '0 : sel_idx_s + IW'(1);
  end

  // Job sequencer: grant, hold start until the multiplier is idle, then
  // follow its busy pulse and capture the product on the falling edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      rr_r      <= '0;
      idx_r     <= '0;
      gnt_r     <= '0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      y_r       <= 24'h000000;
      busy_r    <= 1'b0;
      start_r   <= 1'b0;
      a_r       <= 16'h0000;
      b_r       <= 8'h00;
    end else begin
      gnt_r  <= '0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s) begin
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            idx_r   <= sel_idx_s;
            gnt_r   <= sel_oh_s;
            rr_r    <= rr_next_s;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (!mult_busy_i) begin
            start_r <= 1'b0;
            state_r <= ST_WAIT_HI;
          end else begin
            state_r <= ST_START;
          end
        end
        ST_WAIT_HI: begin
          if (mult_busy_i) begin
            state_r <= ST_WAIT_LO;
          end else begin
            state_r <= ST_WAIT_HI;
          end
        end
        ST_WAIT_LO: begin
          if (!mult_busy_i) begin
            y_r       <= mult_y_i;
            done_id_r <= idx_r;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_LO;
          end
        end
        default: begin
          start_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o        = gnt_r;
  assign done_o       = done_r;
  assign done_id_o    = done_id_r;
  assign y_o          = y_r;
  assign busy_o       = busy_r;
  assign mult_start_o = start_r;
  assign mult_a_o     = a_r;
  assign mult_b_o     = b_r;

endmodule
